// File: rtl/ud_count_monitor.sv
// ud_count_monitor: step checker and event extractor for a 4-bit up/down counter.
// Flags illegal steps, wraps and direction changes; escalates repeated errors to FAULT.
module ud_count_monitor #(
  parameter int WRAP_W    = 8,
  parameter int ERR_LIMIT = 3,
  parameter bit HOLD_OK   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        count,
  input  logic              up_down,
  input  logic              clr_fault,
  output logic              wrap_pulse,
  output logic              wrap_dir,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              dir_change,
  output logic              step_err,
  output logic [3:0]        err_cnt,
  output logic              fault,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_INIT  = 2'b00,
    S_TRACK = 2'b01,
    S_FAULT = 2'b10
  } st_t;

  localparam logic [3:0] LIM = 4'(ERR_LIMIT);

  st_t st_q, st_n;

  logic [3:0]        prev_count;
  logic              prev_ud;
  logic [3:0]        exp_c;
  logic [3:0]        err_inc;
  logic              legal;
  logic              wrap_up;
  logic              wrap_dn;

  logic              wp_n, wd_n, dc_n, se_n, f_n;
  logic [WRAP_W-1:0] wc_n;
  logic [3:0]        ec_n;

  // The step is judged against the direction the counter actually used.
  assign exp_c   = prev_ud ? prev_count + 4'd1 : prev_count - 4'd1;
  assign legal   = (count == exp_c) ||
                   (HOLD_OK && (count == prev_count));
  assign wrap_up = prev_ud && (prev_count == 4'd15) &&
                   (count == 4'd0);
  assign wrap_dn = !prev_ud && (prev_count == 4'd0) &&
                   (count == 4'd15);
  assign err_inc = err_cnt + 4'd1;

  always_comb begin
    st_n = st_q;
    wp_n = 1'b0;
    wd_n = wrap_dir;
    wc_n = wrap_cnt;
    dc_n = 1'b0;
    se_n = 1'b0;
    ec_n = err_cnt;
    f_n  = fault;
    unique case (st_q)
      S_INIT: begin
        st_n = S_TRACK;
        f_n  = 1'b0;
      end
      S_TRACK: begin
        dc_n = (up_down != prev_ud);
        if (!legal) begin
          se_n = 1'b1;
          ec_n = err_inc;
          if (err_inc == LIM) begin
            st_n = S_FAULT;
            f_n  = 1'b1;
          end
        end else if (wrap_up || wrap_dn) begin
          wp_n = 1'b1;
          wd_n = wrap_up;
          if (wrap_cnt != '1)
            wc_n = wrap_cnt + WRAP_W'(1);
        end
      end
      S_FAULT: begin
        f_n = 1'b1;
        if (clr_fault) begin
          st_n = S_INIT;
          f_n  = 1'b0;
          ec_n = 4'd0;
        end
      end
      default: st_n = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= S_INIT;
      prev_count <= 4'd0;
      prev_ud    <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_dir   <= 1'b0;
      wrap_cnt   <= '0;
      dir_change <= 1'b0;
      step_err   <= 1'b0;
      err_cnt    <= 4'd0;
      fault      <= 1'b0;
    end else begin
      st_q       <= st_n;
      prev_count <= count;
      prev_ud    <= up_down;
      wrap_pulse <= wp_n;
      wrap_dir   <= wd_n;
      wrap_cnt   <= wc_n;
      dir_change <= dc_n;
      step_err   <= se_n;
      err_cnt    <= ec_n;
      fault      <= f_n;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_ud_count_monitor.sv
// Scoreboard bench for ud_count_monitor: directed scenarios plus a random run,
// each cycle's expected outputs queued by the driver and checked by a monitor.
module tb_ud_count_monitor;

  localparam int WRAP_W    = 2;
  localparam int ERR_LIMIT = 2;
  localparam bit HOLD_OK   = 1'b0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [3:0]        count = 4'd0;
  logic              up_down = 1'b0;
  logic              clr_fault = 1'b0;
  logic              wrap_pulse;
  logic              wrap_dir;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              dir_change;
  logic              step_err;
  logic [3:0]        err_cnt;
  logic              fault;
  logic [1:0]        state;

  ud_count_monitor #(
    .WRAP_W(WRAP_W),
    .ERR_LIMIT(ERR_LIMIT),
    .HOLD_OK(HOLD_OK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .count(count),
    .up_down(up_down),
    .clr_fault(clr_fault),
    .wrap_pulse(wrap_pulse),
    .wrap_dir(wrap_dir),
    .wrap_cnt(wrap_cnt),
    .dir_change(dir_change),
    .step_err(step_err),
    .err_cnt(err_cnt),
    .fault(fault),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int wp, wd, wc, dc, se, ec, f, st;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  // reference model: mode 0 = waiting for first sample, 1 = checking, 2 = faulted
  int m_mode = 0, m_prev = 0, m_pud = 0;
  int m_wraps = 0, m_errs = 0, m_wdir = 0, m_fault = 0;
  int wrap_max = (1 << WRAP_W) - 1;

  function automatic exp_t model(int r, int c, int ud, int clr);
    exp_t e;
    int nxt;
    e.wp = 0; e.dc = 0; e.se = 0;
    if (r != 0) begin
      m_mode = 0; m_prev = 0; m_pud = 0;
      m_wraps = 0; m_errs = 0; m_wdir = 0; m_fault = 0;
    end else begin
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        nxt = (m_pud != 0) ? (m_prev + 1) % 16 : (m_prev + 15) % 16;
        e.dc = (ud != m_pud) ? 1 : 0;
        if (!(c == nxt || (HOLD_OK && c == m_prev))) begin
          e.se = 1;
          m_errs++;
          if (m_errs == ERR_LIMIT) begin
            m_mode = 2;
            m_fault = 1;
          end
        end else if (m_prev == 15 && c == 0 && m_pud != 0) begin
          e.wp = 1; m_wdir = 1;
          if (m_wraps < wrap_max) m_wraps++;
        end else if (m_prev == 0 && c == 15 && m_pud == 0) begin
          e.wp = 1; m_wdir = 0;
          if (m_wraps < wrap_max) m_wraps++;
        end
      end else if (clr != 0) begin
        m_mode = 0; m_fault = 0; m_errs = 0;
      end
      m_prev = c;
      m_pud  = ud;
    end
    e.wd = m_wdir; e.wc = m_wraps; e.ec = m_errs;
    e.f = m_fault; e.st = m_mode;
    return e;
  endfunction

  task automatic cyc(input int r, input int c, input int ud, input int clr);
    @(negedge clk);
    rst       = r[0];
    count     = c[3:0];
    up_down   = ud[0];
    clr_fault = clr[0];
    q.push_back(model(r, c, ud, clr));
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("wrap_pulse", int'(wrap_pulse), e.wp);
        chk("wrap_dir",   int'(wrap_dir),   e.wd);
        chk("wrap_cnt",   int'(wrap_cnt),   e.wc);
        chk("dir_change", int'(dir_change), e.dc);
        chk("step_err",   int'(step_err),   e.se);
        chk("err_cnt",    int'(err_cnt),    e.ec);
        chk("fault",      int'(fault),      e.f);
        chk("state",      int'(state),      e.st);
      end
    end
  end

  initial begin : driver
    int c, ud, r, clr, pick;
    // reset with random count
    cyc(1, int'($urandom_range(15)), 1, 0);
    cyc(1, int'($urandom_range(15)), 0, 0);
    // up run with wrap
    for (int i = 0; i <= 15; i++) cyc(0, i, 1, 0);
    cyc(0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) cyc(0, i, 1, 0);
    // direction switch at 5, then down wrap
    cyc(0, 5, 0, 0);
    for (int i = 4; i >= 0; i--) cyc(0, i, 0, 0);
    cyc(0, 15, 0, 0);
    for (int i = 14; i >= 3; i--) cyc(0, i, 0, 0);
    // jump, hold -> fault, then a wrap that must be ignored
    cyc(0, 7, 0, 0);
    cyc(0, 7, 0, 0);
    cyc(0, 15, 1, 0);
    cyc(0, 0, 1, 0);
    // clear, unflagged jump in INIT, resume
    cyc(0, 9, 1, 1);
    cyc(0, 2, 1, 0);
    for (int i = 3; i <= 15; i++) cyc(0, i, 1, 0);
    // five more up wraps to saturate
    for (int w = 0; w < 5; w++)
      for (int i = 0; i <= 15; i++) cyc(0, i, 1, 0);
    // fault then rst with clr_fault together
    cyc(0, 9, 1, 0);
    cyc(0, 9, 1, 0);
    cyc(0, 4, 1, 0);
    cyc(1, 4, 1, 1);
    cyc(0, 0, 1, 0);
    // random run
    c = 0; ud = 1;
    for (int n = 0; n < 3000; n++) begin
      pick = int'($urandom_range(99));
      if (pick < 85) c = (ud != 0) ? (c + 1) % 16 : (c + 15) % 16;
      else if (pick >= 95) c = int'($urandom_range(15));
      if ($urandom_range(9) == 0) ud = 1 - ud;
      clr = ($urandom_range(19) == 0) ? 1 : 0;
      r   = ($urandom_range(99) == 0) ? 1 : 0;
      cyc(r, c, ud, clr);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
